// File: rtl/seg_scan4_pkg.sv
// Shared seven-segment display definitions: active-high segment patterns {g,f,e,d,c,b,a},
// digit count and small helpers used by the display stages.
package seg_scan4_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef logic [3:0]                bcd_t;
  typedef logic [NUM_DIGITS*4-1:0]   digits_t;
  typedef logic [1:0]                slot_t;

  // Slot 0 is the leftmost digit, which sits on the highest anode bit.
  function automatic logic [NUM_DIGITS-1:0] slot_anode(input slot_t slot);
    logic [NUM_DIGITS-1:0] an;
    an = '0;
    case (slot)
      2'd0:    an = 4'b1000;
      2'd1:    an = 4'b0100;
      2'd2:    an = 4'b0010;
      default: an = 4'b0001;
    endcase
    return an;
  endfunction

  function automatic bcd_t slot_digit(input digits_t digits, input slot_t slot);
    bcd_t d;
    d = '0;
    case (slot)
      2'd0:    d = digits[15:12];
      2'd1:    d = digits[11:8];
      2'd2:    d = digits[7:4];
      default: d = digits[3:0];
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to seven-segment decode, active-high {g,f,e,d,c,b,a}.
// Codes 10-15 are not valid BCD and render as a dash.
module seg7_decode
  import seg_scan4_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan4.sv
// Four-digit multiplexed seven-segment driver: resynchronises asynchronous BCD digits,
// latches a stable reading once per frame, scans with leading-zero blanking and an anode guard.
module seg_scan4
  import seg_scan4_pkg::*;
#(
  parameter int DIV            = 50000,
  parameter int GUARD          = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int BLANK_LZ       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] AX,
  input  logic [3:0] BX,
  input  logic [3:0] CX,
  input  logic [3:0] DX,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int            CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
  localparam logic [3:0]    AN_OFF    = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;
  localparam logic [6:0]    SEG_IDLE  = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
  localparam logic          DP_OFF    = (SEG_ACTIVE_LOW != 0);

  digits_t       r_s1, r_s2, r_s3;
  digits_t       r_shadow;
  logic [CW-1:0] r_cnt;
  slot_t         r_slot;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  digits_t       w_bus;
  logic          w_cnt_wrap;
  logic          w_frame_end;
  logic          w_stable;
  bcd_t          w_digit;
  logic [6:0]    w_dec;
  logic          w_blank;
  logic          w_lit;
  logic [3:0]    w_an_hi;
  logic [6:0]    w_seg_hi;
  logic [3:0]    w_an_nxt;
  logic [6:0]    w_seg_nxt;

  assign w_bus       = {AX, BX, CX, DX};
  assign w_cnt_wrap  = (r_cnt == CNT_MAX);
  assign w_frame_end = w_cnt_wrap && (r_slot == 2'd3);
  // A bus caught mid-transition shows up as s2 != s3; such a frame keeps the old reading.
  assign w_stable    = (r_s2 == r_s3);

  assign w_digit = slot_digit(r_shadow, r_slot);

  seg7_decode u_decode (
    .i_digit (w_digit),
    .o_seg   (w_dec)
  );

  always_comb begin
    w_blank = 1'b0;
    if (BLANK_LZ != 0) begin
      case (r_slot)
        2'd0:    w_blank = (r_shadow[15:12] == 4'd0);
        2'd1:    w_blank = (r_shadow[15:8]  == 8'd0);
        2'd2:    w_blank = (r_shadow[15:4]  == 12'd0);
        default: w_blank = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_lit    = (r_cnt >= CNT_GUARD) && !w_blank;
    w_an_hi  = w_lit ? slot_anode(r_slot) : 4'h0;
    w_seg_hi = w_lit ? w_dec : SEG_OFF;
    w_an_nxt  = (AN_ACTIVE_LOW  != 0) ? ~w_an_hi  : w_an_hi;
    w_seg_nxt = (SEG_ACTIVE_LOW != 0) ? ~w_seg_hi : w_seg_hi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_s3     <= '0;
      r_shadow <= '0;
      r_cnt    <= '0;
      r_slot   <= '0;
      r_an     <= AN_OFF;
      r_seg    <= SEG_IDLE;
      r_dp     <= DP_OFF;
    end else begin
      r_s1 <= w_bus;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (w_cnt_wrap) begin
        r_cnt  <= '0;
        r_slot <= r_slot + 2'd1;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
      end
      if (w_frame_end && w_stable) begin
        r_shadow <= r_s2;
      end
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
      r_dp  <= DP_OFF;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule
